// File: rtl/audio_dac_tx_if.sv
// ---------------------------------------------------------------------------
// audio_dac_tx_if
// Stereo sample write channel between the playback logic and the DAC
// serializer. One transfer carries a full stereo frame.
//   valid : producer has a frame on left/right
//   ready : consumer can accept a frame this cycle
//   left  : left channel sample, two's complement
//   right : right channel sample, two's complement
// master = sample producer, slave = audio_dac_tx.
// ---------------------------------------------------------------------------
interface audio_dac_tx_if #(
    parameter int DATA_W = 16
) ();
    logic                     valid;
    logic                     ready;
    logic signed [DATA_W-1:0] left;
    logic signed [DATA_W-1:0] right;

    modport master (output valid, output left, output right, input ready);
    modport slave  (input valid, input left, input right, output ready);
endinterface

// File: rtl/audio_dac_tx.sv
// ---------------------------------------------------------------------------
// audio_dac_tx
// Stereo audio DAC serializer for a codec that is bit/frame clock master.
// Frames are buffered in a small FIFO, attenuated by an arithmetic right
// shift and shifted out MSB first in I2S or left-justified framing.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   s             : stereo frame write channel (valid/ready/left/right)
//   enable        : playback enable, captured at frame start
//   mode          : 0 = I2S (one bit delay), 1 = left-justified
//   atten         : right shift 0..15 applied to both channels
//   bclk, daclrc  : codec bit and frame clocks (asynchronous, oversampled)
//   dacdat        : serial data to the codec
//   fifo_level    : frames currently buffered
//   underrun      : one-cycle pulse when a frame starts with an empty FIFO
//   underrun_cnt  : saturating count of underrun frames
// ---------------------------------------------------------------------------
module audio_dac_tx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    audio_dac_tx_if.slave                   s,
    input  logic                            enable,
    input  logic                            mode,
    input  logic [3:0]                      atten,
    input  logic                            bclk,
    input  logic                            daclrc,
    output logic                            dacdat,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underrun,
    output logic [15:0]                     underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] BITS = CW'(DATA_W);

    function automatic logic signed [DATA_W-1:0] attenuate(
        input logic signed [DATA_W-1:0] x,
        input logic [3:0]               sh
    );
        return x >>> sh;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Codec clock synchronisers: _p0/_p1 synchronise, _p2 is history
    logic bclk_p0, bclk_p1, bclk_p2;
    logic lrc_p0, lrc_p1, lrc_p2;
    logic bf, fs, rs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_p0 <= 1'b0;
            bclk_p1 <= 1'b0;
            bclk_p2 <= 1'b0;
            lrc_p0  <= 1'b0;
            lrc_p1  <= 1'b0;
            lrc_p2  <= 1'b0;
            bf      <= 1'b0;
            fs      <= 1'b0;
            rs      <= 1'b0;
        end else begin
            bclk_p0 <= bclk;
            bclk_p1 <= bclk_p0;
            bclk_p2 <= bclk_p1;
            lrc_p0  <= daclrc;
            lrc_p1  <= lrc_p0;
            lrc_p2  <= lrc_p1;
            bf      <= bclk_p2 & ~bclk_p1;
            fs      <= lrc_p2 & ~lrc_p1;
            rs      <= ~lrc_p2 & lrc_p1;
        end
    end

    // Edge pulses registered; FIFO, frame control and serializer act below
    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                push, pop, empty;
    logic [2*DATA_W-1:0] head;
    logic signed [DATA_W-1:0] head_left, head_right;

    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (fifo_level == '0);
    assign s.ready    = (fifo_level != LW'(FIFO_DEPTH));
    assign push       = s.valid & s.ready;
    assign pop        = fs & enable & ~empty;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_left  = head[2*DATA_W-1:DATA_W];
    assign head_right = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s.left, s.right};
        end
    end

    // Pointer width is AW+1 so full and empty are distinguishable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Frame-start capture of settings; right sample held raw until its slot
    logic                     en_lat, mode_lat;
    logic [3:0]               atten_lat;
    logic signed [DATA_W-1:0] hold_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_lat       <= 1'b0;
            mode_lat     <= 1'b0;
            atten_lat    <= 4'd0;
            hold_r       <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            underrun <= fs & enable & empty;
            if (fs) begin
                en_lat    <= enable;
                mode_lat  <= mode;
                atten_lat <= atten;
                hold_r    <= pop ? head_right : '0;
                if (enable && empty) begin
                    underrun_cnt <= sat_inc(underrun_cnt);
                end
            end
        end
    end

    // Load selection: at frame start the incoming settings apply directly
    logic signed [DATA_W-1:0] ld_val;
    logic                     ld_mode;

    always_comb begin
        ld_val  = '0;
        ld_mode = mode_lat;
        if (fs) begin
            ld_mode = mode;
            if (pop) ld_val = attenuate(head_left, atten);
        end else if (en_lat) begin
            ld_val = attenuate(hold_r, atten_lat);
        end
    end

    // Serializer: a load takes priority over a shift in the same cycle.
    // bit_cnt counts bits already presented; past DATA_W the line pads 0.
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            dacdat  <= 1'b0;
        end else if (fs || rs) begin
            if (ld_mode) begin
                dacdat  <= ld_val[DATA_W-1];
                shreg   <= {ld_val[DATA_W-2:0], 1'b0};
                bit_cnt <= CW'(1);
            end else begin
                dacdat  <= 1'b0;
                shreg   <= ld_val;
                bit_cnt <= '0;
            end
        end else if (bf) begin
            if (bit_cnt < BITS) begin
                dacdat  <= shreg[DATA_W-1];
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + CW'(1);
            end else begin
                dacdat <= 1'b0;
            end
        end
    end

endmodule
